riscv_store_checker: RTL and testbench

- Sits directly downstream of the single-cycle RISC-V top and consumes its data-memory store bus (MemWrite, DataAdr, WriteData).
- Turns the pass/fail signature of the self-checking test program into synthesizable hardware. A store of PASS_DATA to PASS_ADDR means pass. Stores to SCRATCH_ADDR are legal. Any other store means fail.
- Adds a cycle timeout, store counters and a small store-log FIFO that the bench or a debug port can drain.

---
 rtl/riscv_chk_pkg.sv | 21 ++
 rtl/store_log_fifo.sv | 59 +++++
 rtl/riscv_store_checker.sv | 126 ++++++++++++
 tb/tb_riscv_store_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_chk_pkg.sv
// Shared types and default constants for the RISC-V store checker.
// The defaults encode the pass/fail signature of the self-checking test program.
package riscv_chk_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } chk_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } log_entry_t;

    localparam logic [31:0] DEFAULT_PASS_ADDR    = 32'd100;
    localparam logic [31:0] DEFAULT_PASS_DATA    = 32'd25;
    localparam logic [31:0] DEFAULT_SCRATCH_ADDR = 32'd96;

endpackage

// File: rtl/store_log_fifo.sv
// Show-ahead synchronous FIFO with a sticky overflow flag for dropped pushes.
// Full and empty are told apart by one extra pointer bit above the index.
module store_log_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign valid     = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok    = pop && valid;
    // A pop on the same edge frees the slot, so a push into a full log still lands.
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_store_checker.sv
// Watches the core's data-memory store bus and turns the test program's
// pass/fail signature into a registered verdict, with counters and a store log.
module riscv_store_checker
    import riscv_chk_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEFAULT_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEFAULT_PASS_DATA,
    parameter logic [31:0] SCRATCH_ADDR   = DEFAULT_SCRATCH_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned LOG_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic [31:0] bad_adr,
    output logic [31:0] bad_data,
    input  logic        log_rd_en,
    output logic        log_valid,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    localparam logic [31:0] LAST_RUN_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    chk_state_t state;
    chk_state_t state_next;
    logic       in_run;
    logic       store_fire;
    logic       is_pass_store;
    logic       is_fail_store;
    logic       expiry;
    logic       log_full;
    log_entry_t push_entry;
    log_entry_t head_entry;

    assign in_run        = (state == RUN);
    assign store_fire    = in_run && MemWrite;
    assign is_pass_store = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
    assign is_fail_store = !is_pass_store && (DataAdr != SCRATCH_ADDR);
    assign expiry        = (cycle_count == LAST_RUN_CYCLE);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A verdict store outranks timeout expiry on the same edge.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        state_next = state;
        if (in_run) begin
            if (store_fire && is_pass_store) begin
                state_next = PASS;
            end else if (store_fire && is_fail_store) begin
                state_next = FAIL;
            end else if (expiry) begin
                state_next = TIMEOUT;
            end
        end
    end

    always_comb begin
        pass    = (state == PASS);
        fail    = (state == FAIL);
        timeout = (state == TIMEOUT);
        done    = !in_run;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            store_count <= '0;
            cycle_count <= '0;
            bad_adr     <= '0;
            bad_data    <= '0;
        end else begin
            if (in_run) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (store_fire && (store_count != 16'hFFFF)) begin
                store_count <= store_count + 16'd1;
            end
            if (store_fire && is_fail_store) begin
                bad_adr  <= DataAdr;
                bad_data <= WriteData;
            end
        end
    end

    assign push_entry = '{adr: DataAdr, data: WriteData};

    store_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH ($bits(log_entry_t))
    ) u_log (
        .clk       (clk),
        .rst       (rst_n),
        .push      (store_fire),
        .push_data (push_entry),
        .pop       (log_rd_en),
        .head_data (head_entry),
        .valid     (log_valid),
        .full      (log_full),
        .overflow  (log_overflow)
    );

    assign log_adr  = head_entry.adr;
    assign log_data = head_entry.data;

    // A store that finds the log full with no pop alongside must raise the sticky flag.
    assert property (@(posedge clk) disable iff (rst_n)
        (store_fire && log_full && !log_rd_en) |=> log_overflow);

endmodule

// File: tb/tb_riscv_store_checker.sv
// Directed bench for riscv_store_checker with hand-computed expectations.
// Built with TIMEOUT_CYCLES=20 and LOG_DEPTH=4 so boundaries are reached quickly.
module tb_riscv_store_checker;

    logic        clk;
    logic        rst_n;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] store_count;
    logic [31:0] cycle_count;
    logic [31:0] bad_adr;
    logic [31:0] bad_data;
    logic        log_rd_en;
    logic        log_valid;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic        log_overflow;

    int tests_run;
    int tests_failed;

    riscv_store_checker #(
        .TIMEOUT_CYCLES (20),
        .LOG_DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .store_count  (store_count),
        .cycle_count  (cycle_count),
        .bad_adr      (bad_adr),
        .bad_data     (bad_data),
        .log_rd_en    (log_rd_en),
        .log_valid    (log_valid),
        .log_adr      (log_adr),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required the bench to finish first");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        MemWrite  = 1'b0;
        log_rd_en = 1'b0;
        tick(1);
        rst_n = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick(1);
        MemWrite = 1'b0;
    endtask

    task automatic pop();
        log_rd_en = 1'b1;
        tick(1);
        log_rd_en = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " verdict"}, {60'd0, done, pass, fail, timeout}, 64'd0);
        check({tag, " counters"}, {16'd0, store_count, cycle_count}, 64'd0);
        check({tag, " bad"}, {bad_adr, bad_data}, 64'd0);
        check({tag, " log flags"}, {62'd0, log_valid, log_overflow}, 64'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] adr, input logic [31:0] data);
        check(tag, {31'd0, log_valid, log_adr, log_data}, {31'd0, 1'b1, adr, data});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        MemWrite     = 1'b0;
        DataAdr      = '0;
        WriteData    = '0;
        log_rd_en    = 1'b0;

        // Pass sequence and in-order log drain
        do_reset();
        check_cleared("reset");
        store(32'd96, 32'd7);
        store(32'd96, 32'd3);
        check("pre-pass done", {63'd0, done}, 64'd0);
        store(32'd100, 32'd25);
        check("pass verdict", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1100});
        check("pass counts", {16'd0, store_count, cycle_count}, {16'd0, 16'd3, 32'd3});
        check_head("log head 0", 32'd96, 32'd7);
        pop();
        check_head("log head 1", 32'd96, 32'd3);
        pop();
        check_head("log head 2", 32'd100, 32'd25);
        pop();
        check("log empty after drain", {63'd0, log_valid}, 64'd0);
        pop();
        check("pop while empty", {63'd0, log_valid}, 64'd0);
        store(32'd104, 32'd1);
        check("store ignored after pass", {16'd0, store_count, 31'd0, fail}, {16'd0, 16'd3, 32'd0});
        check("log ignored after pass", {63'd0, log_valid}, 64'd0);

        // Wrong data at the pass address fails; later stores change nothing
        do_reset();
        store(32'd100, 32'd24);
        check("fail verdict", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1010});
        check("fail bad", {bad_adr, bad_data}, {32'd100, 32'd24});
        store(32'd100, 32'd25);
        check("fail frozen verdict", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1010});
        check("fail frozen bad", {bad_adr, bad_data}, {32'd100, 32'd24});
        check("fail frozen counts", {16'd0, store_count, cycle_count}, {16'd0, 16'd1, 32'd1});

        // Scratch store keeps RUN; stray address fails
        do_reset();
        store(32'd96, 32'd5);
        check("scratch stays run", {60'd0, done, pass, fail, timeout}, 64'd0);
        store(32'd104, 32'd25);
        check("stray fail verdict", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1010});
        check("stray fail bad", {bad_adr, bad_data}, {32'd104, 32'd25});
        check("stray store count", {48'd0, store_count}, 64'd2);

        // Timeout after 20 RUN cycles, then cycle_count freezes
        do_reset();
        tick(19);
        check("timeout not yet", {32'd0, 31'd0, done}, 64'd0);
        check("cycle 19", {32'd0, cycle_count}, 64'd19);
        tick(1);
        check("timeout verdict", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1001});
        check("timeout cycle", {32'd0, cycle_count}, 64'd20);
        tick(3);
        check("cycle frozen", {32'd0, cycle_count}, 64'd20);

        // Pass store on the expiry cycle beats timeout
        do_reset();
        tick(19);
        store(32'd100, 32'd25);
        check("pass beats timeout", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1100});
        check("pass at expiry cycle", {32'd0, cycle_count}, 64'd20);

        // A scratch store on the expiry cycle does not prevent timeout
        do_reset();
        tick(19);
        store(32'd96, 32'd1);
        check("scratch at expiry", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1001});
        check("scratch at expiry count", {48'd0, store_count}, 64'd1);

        // Overflow: six stores into a four-entry log
        do_reset();
        for (int i = 0; i < 6; i++) begin
            store(32'd96, 32'(i));
        end
        check("overflow flags", {61'd0, done, log_valid, log_overflow}, {61'd0, 3'b011});
        check("overflow count", {48'd0, store_count}, 64'd6);
        check_head("overflow head", 32'd96, 32'd0);
        log_rd_en = 1'b1;
        store(32'd96, 32'd6);
        log_rd_en = 1'b0;
        check("push+pop full count", {48'd0, store_count}, 64'd7);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("full drain %0d", i), 32'd96, (i == 3) ? 32'd6 : 32'(i + 1));
            pop();
        end
        check("full drain empty", {63'd0, log_valid}, 64'd0);

        // Reset mid-run after FAIL beats a coincident store, then pass again
        do_reset();
        store(32'd100, 32'd24);
        check("pre-reset fail", {63'd0, fail}, 64'd1);
        rst_n     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd25;
        log_rd_en = 1'b1;
        tick(1);
        rst_n     = 1'b0;
        MemWrite  = 1'b0;
        log_rd_en = 1'b0;
        check_cleared("mid-run reset");
        log_rd_en = 1'b1;
        store(32'd100, 32'd25);
        log_rd_en = 1'b0;
        check("post-reset pass", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1100});
        check_head("push+pop empty", 32'd100, 32'd25);
        check("post-reset count", {48'd0, store_count}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
